// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI3 field widths, response codes and write-arbiter state encoding
package axi_pkg;

    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ADDR = ST_ADDR,
        DATA = ST_DATA,
        RESP = ST_RESP
    } warb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin picker
// Ports: last_grant (index of previous winner), req[1:0], gnt[1:0] one-hot (0 when no request)
module rr_arbiter2 (
    input  logic       last_grant,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // On a tie the master after the previous winner takes the channel.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// rtl/axi_write_arbiter.sv - 2:1 round-robin arbiter sharing one AXI3 write slave (AW/W/B)
// Ports: ACLK, ARESET (async, active high); S_AW*/S_W*/S_B* two flattened master ports
// (master 0 in the LSBs); M_AW*/M_W*/M_B* single slave port; grant one-hot channel owner;
// len_err one-cycle burst-length violation pulse.
// Option: WARB_LEN_CHECK_EN builds the beat counter and len_err; otherwise len_err is 0.
module axi_write_arbiter
    import axi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [2*ID_W-1:0]         S_AWID,
    input  logic [2*ADDR_W-1:0]       S_AWADDR,
    input  logic [2*LEN_W-1:0]        S_AWLEN,
    input  logic [2*SIZE_W-1:0]       S_AWSIZE,
    input  logic [2*BURST_W-1:0]      S_AWBURST,
    input  logic [2*LOCK_W-1:0]       S_AWLOCK,
    input  logic [2*CACHE_W-1:0]      S_AWCACHE,
    input  logic [2*PROT_W-1:0]       S_AWPROT,
    input  logic [1:0]                S_AWVALID,
    output logic [1:0]                S_AWREADY,
    input  logic [2*ID_W-1:0]         S_WID,
    input  logic [2*DATA_W-1:0]       S_WDATA,
    input  logic [2*(DATA_W/8)-1:0]   S_WSTRB,
    input  logic [1:0]                S_WLAST,
    input  logic [1:0]                S_WVALID,
    output logic [1:0]                S_WREADY,
    output logic [2*ID_W-1:0]         S_BID,
    output logic [3:0]                S_BRESP,
    output logic [1:0]                S_BVALID,
    input  logic [1:0]                S_BREADY,
    output logic [ID_W-1:0]           M_AWID,
    output logic [ADDR_W-1:0]         M_AWADDR,
    output logic [LEN_W-1:0]          M_AWLEN,
    output logic [SIZE_W-1:0]         M_AWSIZE,
    output logic [BURST_W-1:0]        M_AWBURST,
    output logic [LOCK_W-1:0]         M_AWLOCK,
    output logic [CACHE_W-1:0]        M_AWCACHE,
    output logic [PROT_W-1:0]         M_AWPROT,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [ID_W-1:0]           M_WID,
    output logic [DATA_W-1:0]         M_WDATA,
    output logic [DATA_W/8-1:0]       M_WSTRB,
    output logic                      M_WLAST,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    input  logic [ID_W-1:0]           M_BID,
    input  logic [1:0]                M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    output logic [1:0]                grant,
    output logic                      len_err
);

    localparam int STRB_W = DATA_W / 8;

    warb_state_e state;
    logic        last_grant;
    logic [1:0]  pick;
    logic        g;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;

`ifdef WARB_LEN_CHECK_EN
    logic [LEN_W-1:0] beat_cnt;
`endif

    logic [ID_W-1:0]    aw_id    [2];
    logic [ADDR_W-1:0]  aw_addr  [2];
    logic [LEN_W-1:0]   aw_len   [2];
    logic [SIZE_W-1:0]  aw_size  [2];
    logic [BURST_W-1:0] aw_burst [2];
    logic [LOCK_W-1:0]  aw_lock  [2];
    logic [CACHE_W-1:0] aw_cache [2];
    logic [PROT_W-1:0]  aw_prot  [2];
    logic [ID_W-1:0]    w_id     [2];
    logic [DATA_W-1:0]  w_data   [2];
    logic [STRB_W-1:0]  w_strb   [2];

    for (genvar i = 0; i < 2; i++) begin : g_unpack
        assign aw_id[i]    = S_AWID[i*ID_W +: ID_W];
        assign aw_addr[i]  = S_AWADDR[i*ADDR_W +: ADDR_W];
        assign aw_len[i]   = S_AWLEN[i*LEN_W +: LEN_W];
        assign aw_size[i]  = S_AWSIZE[i*SIZE_W +: SIZE_W];
        assign aw_burst[i] = S_AWBURST[i*BURST_W +: BURST_W];
        assign aw_lock[i]  = S_AWLOCK[i*LOCK_W +: LOCK_W];
        assign aw_cache[i] = S_AWCACHE[i*CACHE_W +: CACHE_W];
        assign aw_prot[i]  = S_AWPROT[i*PROT_W +: PROT_W];
        assign w_id[i]     = S_WID[i*ID_W +: ID_W];
        assign w_data[i]   = S_WDATA[i*DATA_W +: DATA_W];
        assign w_strb[i]   = S_WSTRB[i*STRB_W +: STRB_W];
    end

    rr_arbiter2 u_rr (
        .last_grant (last_grant),
        .req        (S_AWVALID),
        .gnt        (pick)
    );

    // grant is one-hot whenever the FSM is outside IDLE, so bit 1 is the owner index.
    assign g     = grant[1];
    assign aw_hs = M_AWVALID & M_AWREADY;
    assign w_hs  = M_WVALID & M_WREADY;
    assign b_hs  = M_BVALID & M_BREADY;

    // Channel routing: only the phase currently owned is connected; everything else is 0.
    always_comb begin
        M_AWID    = '0;
        M_AWADDR  = '0;
        M_AWLEN   = '0;
        M_AWSIZE  = '0;
        M_AWBURST = '0;
        M_AWLOCK  = '0;
        M_AWCACHE = '0;
        M_AWPROT  = '0;
        M_AWVALID = 1'b0;
        M_WID     = '0;
        M_WDATA   = '0;
        M_WSTRB   = '0;
        M_WLAST   = 1'b0;
        M_WVALID  = 1'b0;
        M_BREADY  = 1'b0;
        S_AWREADY = '0;
        S_WREADY  = '0;
        S_BVALID  = '0;
        S_BID     = '0;
        S_BRESP   = {RESP_OKAY, RESP_OKAY};
        case (state)
            ADDR: begin
                M_AWID       = aw_id[g];
                M_AWADDR     = aw_addr[g];
                M_AWLEN      = aw_len[g];
                M_AWSIZE     = aw_size[g];
                M_AWBURST    = aw_burst[g];
                M_AWLOCK     = aw_lock[g];
                M_AWCACHE    = aw_cache[g];
                M_AWPROT     = aw_prot[g];
                M_AWVALID    = S_AWVALID[g];
                S_AWREADY[g] = M_AWREADY;
            end
            DATA: begin
                M_WID       = w_id[g];
                M_WDATA     = w_data[g];
                M_WSTRB     = w_strb[g];
`ifdef WARB_LEN_CHECK_EN
                // The counted final beat always closes the burst toward the slave.
                M_WLAST     = S_WLAST[g] | (beat_cnt == '0);
`else
                M_WLAST     = S_WLAST[g];
`endif
                M_WVALID    = S_WVALID[g];
                S_WREADY[g] = M_WREADY;
            end
            RESP: begin
                S_BID       = g ? {M_BID, {ID_W{1'b0}}} : {{ID_W{1'b0}}, M_BID};
                S_BRESP     = g ? {M_BRESP, RESP_OKAY} : {RESP_OKAY, M_BRESP};
                S_BVALID[g] = M_BVALID;
                M_BREADY    = S_BREADY[g];
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= 1'b1;
`ifdef WARB_LEN_CHECK_EN
            beat_cnt   <= '0;
            len_err    <= 1'b0;
`endif
        end else begin
`ifdef WARB_LEN_CHECK_EN
            len_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|S_AWVALID) begin
                        grant <= pick;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
`ifdef WARB_LEN_CHECK_EN
                        beat_cnt <= aw_len[g];
`endif
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
`ifdef WARB_LEN_CHECK_EN
                        beat_cnt <= beat_cnt - 1'b1;
                        // Error whenever the master's WLAST disagrees with the counted last beat.
                        if (S_WLAST[g] != (beat_cnt == '0)) begin
                            len_err <= 1'b1;
                        end
                        if (S_WLAST[g] || (beat_cnt == '0)) begin
                            state <= RESP;
                        end
`else
                        if (S_WLAST[g]) begin
                            state <= RESP;
                        end
`endif
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        last_grant <= g;
                        grant      <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef WARB_LEN_CHECK_EN
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb/tb_axi_write_arbiter.sv - self-checking bench for axi_write_arbiter
module tb_axi_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int STRB_W = DATA_W / 8;
    localparam int BUDGET = 600;

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    logic [2*ID_W-1:0]   S_AWID;
    logic [2*ADDR_W-1:0] S_AWADDR;
    logic [7:0]          S_AWLEN;
    logic [5:0]          S_AWSIZE;
    logic [3:0]          S_AWBURST;
    logic [3:0]          S_AWLOCK;
    logic [7:0]          S_AWCACHE;
    logic [5:0]          S_AWPROT;
    logic [1:0]          S_AWVALID, S_AWREADY;
    logic [2*ID_W-1:0]   S_WID;
    logic [2*DATA_W-1:0] S_WDATA;
    logic [2*STRB_W-1:0] S_WSTRB;
    logic [1:0]          S_WLAST, S_WVALID, S_WREADY;
    logic [2*ID_W-1:0]   S_BID;
    logic [3:0]          S_BRESP;
    logic [1:0]          S_BVALID, S_BREADY;
    logic [ID_W-1:0]     M_AWID;
    logic [ADDR_W-1:0]   M_AWADDR;
    logic [3:0]          M_AWLEN;
    logic [2:0]          M_AWSIZE;
    logic [1:0]          M_AWBURST;
    logic [1:0]          M_AWLOCK;
    logic [3:0]          M_AWCACHE;
    logic [2:0]          M_AWPROT;
    logic                M_AWVALID, M_AWREADY;
    logic [ID_W-1:0]     M_WID;
    logic [DATA_W-1:0]   M_WDATA;
    logic [STRB_W-1:0]   M_WSTRB;
    logic                M_WLAST, M_WVALID, M_WREADY;
    logic [ID_W-1:0]     M_BID;
    logic [1:0]          M_BRESP;
    logic                M_BVALID, M_BREADY;
    logic [1:0]          grant;
    logic                len_err;

    axi_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
        .S_AWBURST(S_AWBURST), .S_AWLOCK(S_AWLOCK), .S_AWCACHE(S_AWCACHE), .S_AWPROT(S_AWPROT),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WID(S_WID), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
        .M_AWBURST(M_AWBURST), .M_AWLOCK(M_AWLOCK), .M_AWCACHE(M_AWCACHE), .M_AWPROT(M_AWPROT),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WID(M_WID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .grant(grant), .len_err(len_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Per-master transaction under test.
    logic [ID_W-1:0]   t_id    [2];
    logic [ADDR_W-1:0] t_addr  [2];
    logic [3:0]        t_len   [2];
    logic [2:0]        t_size  [2];
    logic [1:0]        t_burst [2];
    logic [1:0]        t_lock  [2];
    logic [3:0]        t_cache [2];
    logic [2:0]        t_prot  [2];
    logic [DATA_W-1:0] t_data  [2][16];
    logic [STRB_W-1:0] t_strb  [2][16];
    int                t_last_at [2];
    bit                active [2];
    bit                awdone [2];
    bit                wdone  [2];
    int                wbeat  [2];

    // Slave model and arbitration reference.
    bit              s_bpend;
    logic [ID_W-1:0] s_bid;
    logic [1:0]      s_bresp;
    int              s_beat;
    int              last_owner;
    int              exp_owner;
    int              arb_wait;
    int              len_err_cnt;
    int              exp_len_err;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic new_txn(input int m, input int len, input int last_at);
        t_id[m]    = ID_W'($urandom);
        t_addr[m]  = $urandom;
        t_len[m]   = 4'(len);
        t_size[m]  = 3'($urandom);
        t_burst[m] = 2'($urandom);
        t_lock[m]  = 2'($urandom);
        t_cache[m] = 4'($urandom);
        t_prot[m]  = 3'($urandom);
        t_last_at[m] = last_at;
        for (int i = 0; i < 16; i++) begin
            t_data[m][i] = $urandom;
            t_strb[m][i] = STRB_W'($urandom);
        end
    endtask

    task automatic drive();
        for (int m = 0; m < 2; m++) begin
            S_AWID[m*ID_W +: ID_W]       = t_id[m];
            S_AWADDR[m*ADDR_W +: ADDR_W] = t_addr[m];
            S_AWLEN[m*4 +: 4]            = t_len[m];
            S_AWSIZE[m*3 +: 3]           = t_size[m];
            S_AWBURST[m*2 +: 2]          = t_burst[m];
            S_AWLOCK[m*2 +: 2]           = t_lock[m];
            S_AWCACHE[m*4 +: 4]          = t_cache[m];
            S_AWPROT[m*3 +: 3]           = t_prot[m];
            S_AWVALID[m]                 = active[m] && !awdone[m];
            S_WID[m*ID_W +: ID_W]        = t_id[m];
            S_WDATA[m*DATA_W +: DATA_W]  = t_data[m][wbeat[m]];
            S_WSTRB[m*STRB_W +: STRB_W]  = t_strb[m][wbeat[m]];
            S_WLAST[m]                   = (wbeat[m] == t_last_at[m]);
            S_WVALID[m]                  = active[m] && awdone[m] && !wdone[m];
            S_BREADY[m]                  = 1'($urandom_range(0, 1));
        end
        M_AWREADY = 1'($urandom_range(0, 1));
        M_WREADY  = ($urandom_range(0, 3) != 0);
        M_BVALID  = s_bpend;
        M_BID     = s_bid;
        M_BRESP   = s_bresp;
    endtask

    task automatic sample();
        logic [1:0] eg;
        logic [7:0] quiet;
        bit         exp_last;
        eg = (exp_owner == 0) ? 2'b01 : 2'b10;
        if (len_err) len_err_cnt++;

        // One idle cycle precedes every grant, and M_AWVALID follows the grant at once.
        if (arb_wait == 0 || arb_wait == 2) begin
            check("idle_cycle", {grant, M_AWVALID}, 3'b000);
            arb_wait = (arb_wait == 0) ? 1 : -1;
        end else if (arb_wait == 1) begin
            check("arb_grant", {grant, M_AWVALID}, {eg, 1'b1});
            arb_wait = -1;
        end

        check("grant_onehot0", 1'($onehot0(grant)), 1'b1);
        quiet = '0;
        for (int m = 0; m < 2; m++) begin
            if (!grant[m]) begin
                quiet |= {S_AWREADY[m], S_WREADY[m], S_BVALID[m], S_BRESP[2*m +: 2], 1'b0, 2'b00};
                quiet[ID_W-1:0] |= S_BID[m*ID_W +: ID_W];
            end
        end
        if (grant == 2'b00) quiet[7:5] |= {M_AWVALID, M_WVALID, M_BREADY};
        check("ungranted_quiet", quiet, 8'h00);

        if (M_AWVALID && M_AWREADY) begin
            check("aw_route", S_AWREADY & S_AWVALID, eg);
            check("aw_payload",
                  {M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWLOCK, M_AWCACHE, M_AWPROT},
                  {t_id[exp_owner], t_addr[exp_owner], t_len[exp_owner], t_size[exp_owner],
                   t_burst[exp_owner], t_lock[exp_owner], t_cache[exp_owner], t_prot[exp_owner]});
            awdone[exp_owner] = 1'b1;
            s_beat = 0;
        end

        if (M_WVALID && M_WREADY) begin
`ifdef WARB_LEN_CHECK_EN
            exp_last = (s_beat == t_last_at[exp_owner]) || (s_beat == int'(t_len[exp_owner]));
            if ((s_beat == t_last_at[exp_owner]) != (s_beat == int'(t_len[exp_owner]))) exp_len_err++;
`else
            exp_last = (s_beat == t_last_at[exp_owner]);
`endif
            check("w_route", S_WREADY & S_WVALID, eg);
            check("w_beat", {M_WID, M_WDATA, M_WSTRB, M_WLAST},
                  {t_id[exp_owner], t_data[exp_owner][s_beat], t_strb[exp_owner][s_beat], exp_last});
            if (exp_last) begin
                wdone[exp_owner] = 1'b1;
                s_bpend = 1'b1;
                s_bid   = t_id[exp_owner];
                s_bresp = 2'($urandom);
            end else begin
                wbeat[exp_owner]++;
            end
            s_beat++;
        end

        if (M_BVALID && M_BREADY) begin
            check("b_route", {S_BVALID, S_BREADY & S_BVALID}, {eg, eg});
            if (exp_owner == 0)
                check("b_payload", {S_BID[ID_W-1:0], S_BRESP[1:0]}, {s_bid, s_bresp});
            else
                check("b_payload", {S_BID[2*ID_W-1:ID_W], S_BRESP[3:2]}, {s_bid, s_bresp});
            active[exp_owner] = 1'b0;
            s_bpend    = 1'b0;
            last_owner = exp_owner;
            if (active[1-exp_owner]) begin
                exp_owner = 1 - exp_owner;
                arb_wait  = 0;
            end else begin
                arb_wait  = 2;
            end
        end
    endtask

    // Reference arbitration: on a tie the previous winner loses; a lone requester always wins.
    task automatic run_round(input bit [1:0] mask, input int stop_beat);
        int cyc;
        cyc = 0;
        for (int m = 0; m < 2; m++) begin
            active[m] = mask[m];
            awdone[m] = 1'b0;
            wdone[m]  = 1'b0;
            wbeat[m]  = 0;
        end
        exp_owner   = (mask == 2'b11) ? (1 - last_owner) : (mask[0] ? 0 : 1);
        arb_wait    = 0;
        len_err_cnt = 0;
        exp_len_err = 0;
        while ((active[0] || active[1]) && cyc < BUDGET) begin
            if (stop_beat >= 0 && wbeat[0] == stop_beat) break;
            drive();
            #1;
            sample();
            @(negedge ACLK);
            cyc++;
        end
        check("round_in_budget", 1'(cyc < BUDGET), 1'b1);
        if (stop_beat < 0) check("len_err_count", 32'(len_err_cnt), 32'(exp_len_err));
    endtask

    task automatic clear_model();
        for (int m = 0; m < 2; m++) begin
            active[m] = 1'b0;
            awdone[m] = 1'b0;
            wdone[m]  = 1'b0;
            wbeat[m]  = 0;
        end
        s_bpend    = 1'b0;
        s_bid      = '0;
        s_bresp    = '0;
        s_beat     = 0;
        last_owner = 1;
        exp_owner  = 0;
        arb_wait   = -1;
    endtask

    initial begin
        int len;
        ARESET = 1'b1;
        clear_model();
        new_txn(0, 0, 0);
        new_txn(1, 0, 0);
        drive();
        repeat (2) @(negedge ACLK);
        check("reset_state",
              {grant, S_AWREADY, S_WREADY, S_BVALID, M_AWVALID, M_WVALID, M_BREADY, len_err}, '0);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Both masters request right after reset: master 0 first, then master 1.
        new_txn(0, 1, 1);
        new_txn(1, 2, 2);
        run_round(2'b11, -1);

        // Single master 0 burst: address 0x2, four beats of 1..4.
        new_txn(0, 3, 3);
        t_addr[0] = 32'h2;
        for (int i = 0; i < 4; i++) t_data[0][i] = DATA_W'(i + 1);
        run_round(2'b01, -1);

        // Continuous contention: grants alternate across four transactions.
        for (int r = 0; r < 2; r++) begin
            new_txn(0, int'($urandom_range(0, 15)), 0);
            t_last_at[0] = int'(t_len[0]);
            new_txn(1, int'($urandom_range(0, 15)), 0);
            t_last_at[1] = int'(t_len[1]);
            run_round(2'b11, -1);
        end

        // Random request patterns with random slave and master backpressure.
        for (int r = 0; r < 10; r++) begin
            for (int m = 0; m < 2; m++) begin
                len = int'($urandom_range(0, 15));
                new_txn(m, len, len);
            end
            run_round(2'($urandom_range(1, 3)), -1);
        end

        // Reset in the middle of a burst, after two beats have been accepted.
        new_txn(0, 3, 3);
        run_round(2'b01, 2);
        ARESET = 1'b1;
        #1;
        check("mid_burst_reset",
              {grant, S_AWREADY, S_WREADY, S_BVALID, M_AWVALID, M_WVALID, M_BREADY, len_err}, '0);
        clear_model();
        drive();
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Normal arbitration resumes with master 0 winning the first tie.
        new_txn(0, 2, 2);
        new_txn(1, 0, 0);
        run_round(2'b11, -1);

`ifdef WARB_LEN_CHECK_EN
        // WLAST on the second beat of a four-beat burst.
        new_txn(0, 3, 1);
        run_round(2'b01, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_write_arbiter.md
# axi_write_arbiter

Two-to-one arbiter that shares a single AXI3 write-channel slave (AW/W/B) between two write masters. It sits between the write-master instances and the write-slave instance and grants the whole write transaction, address through response, to one master at a time using round-robin priority. It routes the write-data beats and the write response back to the granted master and keeps the other master stalled.

## Interface
Parameters:
- DATA_W, 32, WDATA width; WSTRB width is DATA_W/8
- ADDR_W, 32, AWADDR width
- ID_W, 4, AWID/WID/BID width

Ports (master-facing buses are flattened 2×; master 0 occupies the LSBs):
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- S_AWID/S_AWADDR/S_AWLEN/S_AWSIZE/S_AWBURST/S_AWLOCK/S_AWCACHE/S_AWPROT  in  2×(ID_W/ADDR_W/4/3/2/2/4/3)  per-master write-address payload
- S_AWVALID  in  2  per-master address valid
- S_AWREADY  out  2  per-master address ready
- S_WID/S_WDATA/S_WSTRB/S_WLAST  in  2×(ID_W/DATA_W/DATA_W/8/1)  per-master write-data payload
- S_WVALID  in  2  per-master data valid
- S_WREADY  out  2  per-master data ready
- S_BID/S_BRESP  out  2×(ID_W/2)  per-master response payload
- S_BVALID  out  2  per-master response valid
- S_BREADY  in  2  per-master response ready
- M_AW*  out  single-width copies of the AW payload, plus M_AWVALID out 1 and M_AWREADY in 1
- M_W*  out  WID/WDATA/WSTRB/WLAST, plus M_WVALID out 1 and M_WREADY in 1
- M_BID/M_BRESP/M_BVALID  in  response from the slave; M_BREADY out 1
- grant  out  2  one-hot owner of the channel; 0 when idle
- len_err  out  1  one-cycle pulse on a burst-length violation (only when WARB_LEN_CHECK_EN is defined)

## Operation
- FSM states: IDLE → ADDR → DATA → RESP → IDLE.
- IDLE:
  - If any S_AWVALID is high, pick the winner by round-robin. The master after last_grant wins ties. After reset last_grant=1, so master 0 wins the first tie.
  - Register the winner in grant and move to ADDR. No ready is asserted while in IDLE.
- ADDR:
  - Pass the granted AW payload and valid to M_AW*. M_AWREADY is routed to the granted S_AWREADY.
  - On the AW handshake, latch AWLEN into beat_cnt and move to DATA.
- DATA:
  - Mux the granted W channel to M_W*; M_WREADY goes only to the granted master.
  - Each accepted beat decrements beat_cnt.
  - On the handshake with WLAST=1, move to RESP.
- RESP:
  - Route M_BID/M_BRESP/M_BVALID to the granted master; that master's S_BREADY drives M_BREADY.
  - On the B handshake, set last_grant=grant, clear grant and return to IDLE.
- The non-granted master sees all of its ready and valid outputs held at 0, and its payload outputs held at 0.
- A master that drops S_AWVALID before AWREADY violates AXI. No recovery is required, but the FSM must not deadlock in ADDR while the master still holds valid.

## Timing
- Reset values: grant=0; every S_*READY, S_BVALID, M_AWVALID, M_WVALID, M_BREADY and len_err =0; state=IDLE; beat_cnt=0.
- Arbitration latency: one cycle. S_AWVALID sampled in IDLE gives M_AWVALID=1 in the next cycle.
- M_AWVALID, M_WVALID and S_BVALID are combinational pass-throughs once granted. The ready paths are combinational; no extra pipeline stage is added.
- Minimum transaction length is 4 cycles for AWLEN=0: arbitration, AW, one W beat, B.
- Back-to-back transactions: the next arbitration starts in the cycle after the B handshake, so there is one idle cycle between transactions.
- Requests from both masters in the same cycle are resolved by round-robin. Strict alternation holds while both keep requesting.
- ARESET asserted mid-burst returns the block to the reset state immediately. Outstanding beats are dropped.

## Configuration
- WARB_LEN_CHECK_EN defined:
  - A WLAST arriving with beat_cnt≠0, or beat_cnt reaching 0 without WLAST, pulses len_err for one cycle.
  - In the second case the FSM still goes to RESP, and M_WLAST is forced to 1 on that final beat.
- Undefined: len_err is tied to 0, beat_cnt is not built, and the DATA exit depends only on WLAST.

## Structure
- Shared package axi_pkg holds:
  - state encoding localparams (IDLE/ADDR/DATA/RESP)
  - BRESP codes (OKAY=2'b00, EXOKAY, SLVERR, DECERR)
  - AXI field widths (LEN_W=4, SIZE_W=3, BURST_W=2, LOCK_W=2, CACHE_W=4, PROT_W=3)
- One sub-module, rr_arbiter2: a 2-input round-robin picker with a last-grant input, producing a one-hot output.

## Test plan
- Single request: master 0 writes AWADDR=0x2, AWLEN=3, data 1..4 → grant=01, 4 beats reach M_WDATA in order, BRESP=OKAY delivered only to S_BVALID[0], grant=0 afterwards.
- Simultaneous requests right after reset → master 0 is served first, then master 1 with exactly one idle cycle between; grant sequence 01,00,10.
- Continuous requests from both masters over 4 transactions → grants alternate 01,10,01,10.
- Slave backpressure: M_WREADY low for 3 cycles mid-burst → no beat lost or duplicated; master 1 gets S_WREADY=0 throughout.
- ARESET pulse during DATA beat 2 → all outputs reach reset values in the same cycle; the next request is arbitrated normally.
- With WARB_LEN_CHECK_EN: AWLEN=3 but WLAST on beat 2 → len_err pulses once, FSM enters RESP, B still completes.
